// File: rtl/rv32_pkg.sv
// rv32_pkg: shared widths, register-file geometry and writeback source IDs
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    function automatic logic [1:0] src_onehot(input src_e s);
        return (s == SRC_ALU) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, req[0]=ALU, req[1]=LSU
module rr_arbiter2
    import rv32_pkg::*;
(
    input  logic       clk,
    input  logic       aresetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e last;

    always_comb gnt = (req == 2'b11) ? src_onehot((last == SRC_ALU) ? SRC_LSU : SRC_ALU) : req;

    // Reset to LSU so the ALU wins the first contest
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            last <= SRC_LSU;
        else if (|req)
            last <= gnt[1] ? SRC_LSU : SRC_ALU;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU/LSU writebacks onto one register-file write port and scoreboards pending writes
module regfile_wb_scheduler
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MAX_OUT = 3,
    parameter int CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_full,
    output logic [NUM_REGS-1:0]   busy,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]       rf_wr_data,
    output logic                  sb_err
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

    logic [1:0]            gnt;
    logic [CNT_W-1:0]      cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   inc;
    logic [NUM_REGS-1:0]   dec;
    logic                  at_max;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .aresetn (aresetn),
        .req     ({lsu_valid, alu_valid}),
        .gnt     (gnt)
    );

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign sel_rd    = gnt[1] ? lsu_rd : alu_rd;
    assign sel_data  = gnt[1] ? lsu_data : alu_data;

    always_comb begin
        at_max     = cnt[issue_rd] == MAX_C;
        issue_full = issue_en && issue_rd != '0 && at_max;
        inc        = '0;
        dec        = '0;
        inc[issue_rd]   = issue_en && issue_rd != '0 && !at_max;
        dec[rf_wr_addr] = rf_wr_en;
        for (int r = 0; r < NUM_REGS; r++)
            busy[r] = cnt[r] != '0;
    end

    // A handshake to x0 completes but never reaches the register file
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            rf_wr_en <= (|gnt) && sel_rd != '0;
            if (|gnt) begin
                rf_wr_addr <= sel_rd;
                rf_wr_data <= sel_data;
            end
        end
    end

    // cnt[0] is only ever written by reset, so it stays zero
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec[r] && !inc[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            sb_err <= sb_err | (rf_wr_en && cnt[rf_wr_addr] == '0);
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: table-driven arbitration vectors plus directed scoreboard sequences
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        aresetn = 1'b1;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_full;
    logic [31:0] busy;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ear;
        logic        elr;
        logic        een;
        logic [4:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] c_ad [4];
    logic [31:0] c_ld [4];
    logic        c_ar [4];
    logic [4:0]  c_addr [4];
    logic [31:0] c_data [4];

    regfile_wb_scheduler #(.XLEN(32), .MAX_OUT(3), .CNT_W(2)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .issue_full (issue_full),
        .busy       (busy),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_en  = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 5'd1,  32'h11,   1, 5'd2,  32'h22,   1, 0, 1, 5'd1,  32'h11};
        tbl[1]  = '{1, 5'd3,  32'h33,   1, 5'd2,  32'h22,   0, 1, 1, 5'd2,  32'h22};
        tbl[2]  = '{1, 5'd3,  32'h33,   1, 5'd4,  32'h44,   1, 0, 1, 5'd3,  32'h33};
        tbl[3]  = '{1, 5'd5,  32'h55,   1, 5'd4,  32'h44,   0, 1, 1, 5'd4,  32'h44};
        tbl[4]  = '{0, 5'd0,  32'h0,    1, 5'd6,  32'h66,   0, 1, 1, 5'd6,  32'h66};
        tbl[5]  = '{1, 5'd5,  32'h55,   1, 5'd7,  32'h77,   1, 0, 1, 5'd5,  32'h55};
        tbl[6]  = '{1, 5'd8,  32'h88,   0, 5'd7,  32'h77,   1, 0, 1, 5'd8,  32'h88};
        tbl[7]  = '{1, 5'd9,  32'h99,   1, 5'd7,  32'h77,   0, 1, 1, 5'd7,  32'h77};
        tbl[8]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 0, 0, 5'd0,  32'h0};
        tbl[9]  = '{1, 5'd9,  32'h99,   1, 5'd10, 32'h1010, 1, 0, 1, 5'd9,  32'h99};
        tbl[10] = '{1, 5'd0,  32'hFF,   0, 5'd0,  32'h0,    1, 0, 0, 5'd0,  32'h0};
        tbl[11] = '{1, 5'd10, 32'hAA,   1, 5'd0,  32'hBB,   0, 1, 0, 5'd0,  32'h0};
        tbl[12] = '{1, 5'd12, 32'hC,    0, 5'd0,  32'h0,    1, 0, 1, 5'd12, 32'hC};

        c_ad   = '{32'hA0, 32'hA1, 32'hA1, 32'hA2};
        c_ld   = '{32'hB0, 32'hB0, 32'hB1, 32'hB1};
        c_ar   = '{1'b1, 1'b0, 1'b1, 1'b0};
        c_addr = '{5'd1, 5'd2, 5'd1, 5'd2};
        c_data = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};

        #1 aresetn = 1'b0;
        #2;
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_wr_addr", rf_wr_addr, 0);
        chk("rst_wr_data", rf_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sb_err", sb_err, 0);
        @(negedge clk) aresetn = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].ear);
            chk($sformatf("v%0d_lsu_ready", i), lsu_ready, tbl[i].elr);
            tick();
            chk($sformatf("v%0d_wr_en", i), rf_wr_en, tbl[i].een);
            if (tbl[i].een) begin
                chk($sformatf("v%0d_wr_addr", i), rf_wr_addr, tbl[i].eaddr);
                chk($sformatf("v%0d_wr_data", i), rf_wr_data, tbl[i].edata);
            end
        end
        idle();
        tick();

        // reset in the middle of a transfer
        issue_en = 1; issue_rd = 5'd20;
        alu_valid = 1; alu_rd = 5'd11; alu_data = 32'h1111;
        lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'h1212;
        tick();
        idle();
        chk("mid_wr_en", rf_wr_en, 1);
        chk("mid_busy20", busy[20], 1);
        chk("mid_sb_err", sb_err, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_wr_en", rf_wr_en, 0);
        chk("arst_wr_addr", rf_wr_addr, 0);
        chk("arst_wr_data", rf_wr_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sb_err", sb_err, 0);
        @(negedge clk) aresetn = 1'b1;
        alu_valid = 1; alu_rd = 5'd0;
        lsu_valid = 1; lsu_rd = 5'd0;
        #1;
        chk("arst_alu_first", alu_ready, 1);
        chk("arst_lsu_lose", lsu_ready, 0);
        tick();
        idle();

        // single ALU write to x5
        issue_en = 1; issue_rd = 5'd5;
        #1 chk("x5_issue_full", issue_full, 0);
        tick();
        issue_en = 0;
        chk("x5_busy_issued", busy[5], 1);
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("x5_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        chk("x5_wr_en", rf_wr_en, 1);
        chk("x5_wr_addr", rf_wr_addr, 5);
        chk("x5_wr_data", rf_wr_data, 32'hDEADBEEF);
        chk("x5_busy_commit", busy[5], 1);
        tick();
        chk("x5_wr_en_off", rf_wr_en, 0);
        chk("x5_busy_clear", busy[5], 0);

        // make LSU the last grant, then issue x1 and x2 twice each
        lsu_valid = 1; lsu_rd = 5'd0;
        tick();
        lsu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            issue_en = 1; issue_rd = (i < 2) ? 5'd1 : 5'd2;
            tick();
        end
        issue_en = 0;

        // both sources contending for four cycles
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'd1; alu_data = c_ad[i];
            lsu_valid = 1; lsu_rd = 5'd2; lsu_data = c_ld[i];
            #1;
            chk($sformatf("alt%0d_alu_ready", i), alu_ready, c_ar[i]);
            chk($sformatf("alt%0d_lsu_ready", i), lsu_ready, !c_ar[i]);
            tick();
            chk($sformatf("alt%0d_wr_en", i), rf_wr_en, 1);
            chk($sformatf("alt%0d_wr_addr", i), rf_wr_addr, c_addr[i]);
            chk($sformatf("alt%0d_wr_data", i), rf_wr_data, c_data[i]);
        end
        idle();
        tick();
        chk("alt_busy1", busy[1], 0);
        chk("alt_busy2", busy[2], 0);
        chk("alt_sb_err", sb_err, 0);

        // saturate x7
        for (int i = 0; i < 3; i++) begin
            issue_en = 1; issue_rd = 5'd7;
            #1 chk($sformatf("x7_full%0d", i), issue_full, 0);
            tick();
        end
        chk("x7_busy", busy[7], 1);
        #1 chk("x7_full_4th", issue_full, 1);
        tick();
        issue_rd = 5'd0;
        #1 chk("x0_full", issue_full, 0);
        issue_en = 0;
        alu_valid = 1; alu_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            alu_data = i;
            tick();
        end
        alu_valid = 0;
        chk("x7_busy_one_left", busy[7], 1);
        tick();
        chk("x7_busy_clear", busy[7], 0);
        chk("x7_sb_err", sb_err, 0);

        // issue and commit to x9 in the same cycle
        issue_en = 1; issue_rd = 5'd9;
        tick();
        issue_en = 0;
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9999;
        tick();
        alu_valid = 0;
        chk("x9_commit_en", rf_wr_en, 1);
        issue_en = 1; issue_rd = 5'd9;
        tick();
        issue_en = 0;
        chk("x9_busy_held", busy[9], 1);
        chk("x9_sb_err", sb_err, 0);
        alu_valid = 1;
        tick();
        alu_valid = 0;
        tick();
        chk("x9_busy_clear", busy[9], 0);
        chk("x9_sb_err_end", sb_err, 0);

        // write to x0, then an unscoreboarded commit to x3
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1 chk("x0_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        chk("x0_wr_en", rf_wr_en, 0);
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h3333;
        tick();
        alu_valid = 0;
        chk("x3_wr_en", rf_wr_en, 1);
        chk("x3_sb_err_pre", sb_err, 0);
        tick();
        chk("x3_sb_err", sb_err, 1);
        chk("x3_busy", busy[3], 0);
        tick();
        tick();
        tick();
        chk("x3_sb_err_sticky", sb_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
